// File: rtl/int2float_seq.sv
// ============================================================================
// Module   : int2float_seq
// Purpose  : Multi-cycle 32-bit integer to IEEE-754 single converter with
//            valid/ready handshakes. INT2FLOAT_FAST_NORM_EN selects one-cycle
//            normalisation instead of the bit-serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int2float_seq #(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] float_out,
    output logic        precision_lost,
    output logic        zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] float_q, float_d;
    logic        pl_q, pl_d;
    logic        zero_q, zero_d;

    logic        w_in_sign;
    logic [31:0] w_in_mag;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_up;
    logic [30:0] w_rounded;

    assign w_in_sign = is_signed & int_in[31];
    assign w_in_mag  = w_in_sign ? (~int_in + 32'd1) : int_in;

    // Rounding acts on the normalised magnitude; a mantissa carry ripples into the exponent.
    assign w_mant    = mag_q[30:8];
    assign w_guard   = mag_q[7];
    assign w_sticky  = |mag_q[6:0];
    assign w_up      = (ROUND_MODE == 0) && w_guard && (w_sticky || w_mant[0]);
    assign w_rounded = {exp_q, w_mant} + {30'd0, w_up};

`ifdef INT2FLOAT_FAST_NORM_EN
    logic [4:0]  w_lz;
    logic [31:0] w_norm_mag;
    logic [7:0]  w_norm_exp;

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag_q[i]) begin
                w_lz = 5'(31 - i);
            end
        end
    end

    assign w_norm_mag = mag_q << w_lz;
    assign w_norm_exp = 8'd158 - {3'd0, w_lz};
`endif

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        float_d = float_q;
        pl_d    = pl_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = w_in_sign;
                    mag_d  = w_in_mag;
                    exp_d  = 8'd158;
                    if (w_in_mag == 32'd0) begin
                        float_d = 32'd0;
                        pl_d    = 1'b0;
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
`ifdef INT2FLOAT_FAST_NORM_EN
                mag_d   = w_norm_mag;
                exp_d   = w_norm_exp;
                state_d = S_ROUND;
`else
                // The cycle that finds the MSB in place also rounds, keeping latency at L+2.
                if (!mag_q[31]) begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end else begin
                    float_d = {sign_q, w_rounded};
                    pl_d    = w_guard | w_sticky;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end
`endif
            end
            S_ROUND: begin
                float_d = {sign_q, w_rounded};
                pl_d    = w_guard | w_sticky;
                zero_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_q   <= 32'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
            float_q <= 32'd0;
            pl_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            float_q <= float_d;
            pl_q    <= pl_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE) && !rst;
    assign out_valid      = (state_q == S_DONE);
    assign float_out      = float_q;
    assign precision_lost = pl_q;
    assign zero           = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_int2float_seq.sv
// ============================================================================
// Module   : tb_int2float_seq
// Purpose  : Self-checking bench for int2float_seq (RNE and RTZ instances)
//            against an arithmetic reference conversion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int2float_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] int_in = 32'd0;
    logic        is_signed = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, pl0, zero0;
    logic        in_ready1, out_valid1, pl1, zero1;
    logic [31:0] float0, float1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int2float_seq #(.ROUND_MODE(0)) dut_rne (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .int_in(int_in), .is_signed(is_signed), .out_valid(out_valid0),
        .out_ready(out_ready), .float_out(float0), .precision_lost(pl0),
        .zero(zero0)
    );

    int2float_seq #(.ROUND_MODE(1)) dut_rtz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .int_in(int_in), .is_signed(is_signed), .out_valid(out_valid1),
        .out_ready(out_ready), .float_out(float1), .precision_lost(pl1),
        .zero(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer -> float via magnitude, exponent search and remainder rounding.
    task automatic ref_conv(input logic [31:0] v, input logic sg, input int mode,
                            output logic [31:0] f, output logic pl, output logic z,
                            output int lat);
        longint sv, m, q, rem, half;
        logic   neg;
        int     e, sh;
        sv  = sg ? longint'($signed(v)) : longint'({32'd0, v});
        neg = (sv < 0);
        m   = neg ? -sv : sv;
        f = 32'd0; pl = 1'b0; z = 1'b0;
        if (m == 0) begin
            z   = 1'b1;
            lat = 1;
        end else begin
            e = 0;
            while ((m >> (e + 1)) != 0) e++;
`ifdef INT2FLOAT_FAST_NORM_EN
            lat = 3;
`else
            lat = (31 - e) + 2;
`endif
            rem = 0;
            if (e <= 23) begin
                q = m << (23 - e);
            end else begin
                sh   = e - 23;
                q    = m >> sh;
                rem  = m - (q << sh);
                half = 64'sd1 << (sh - 1);
                if (mode == 0 && (rem > half || (rem == half && q[0]))) q++;
                if (q == (64'sd1 << 24)) begin
                    q = q >> 1;
                    e++;
                end
            end
            pl = (rem != 0);
            f  = {neg, 8'(e + 127), q[22:0]};
        end
    endtask

    // Runs one conversion from an idle negedge; optionally stalls the consumer.
    task automatic convert(input logic [31:0] v, input logic sg, input int hold);
        logic [31:0] ef0, ef1, held;
        logic        ep0, ep1, ez0, ez1;
        int          el, el1, n;
        ref_conv(v, sg, 0, ef0, ep0, ez0, el);
        ref_conv(v, sg, 1, ef1, ep1, ez1, el1);
        chk("in_ready_idle", 32'(in_ready0), 32'd1);
        int_in = v; is_signed = sg; in_valid = 1'b1;
        n = 0;
        @(posedge clk); n++;
        @(negedge clk);
        in_valid = 1'b0;
        int_in = $urandom;
        while (!out_valid0 && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'(el));
        chk("rne_float", float0, ef0);
        chk("rne_pl", 32'(pl0), 32'(ep0));
        chk("rne_zero", 32'(zero0), 32'(ez0));
        chk("rtz_valid", 32'(out_valid1), 32'd1);
        chk("rtz_float", float1, ef1);
        chk("rtz_pl", 32'(pl1), 32'(ep1));
        held = float0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; int_in = $urandom; is_signed = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_float", float0, held);
            chk("hold_valid_busy", {30'd0, out_valid0, in_ready0}, 32'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_handshake", {30'd0, in_ready0, out_valid0}, 32'd2);
        chk("result_kept", float0, ef0);
    endtask

    initial begin
        logic [31:0] rv;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready0), 32'd0);
        chk("reset_state", {float0[30:0], out_valid0}, 32'd0);
        chk("reset_flags", {30'd0, pl0, zero0}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        convert(32'h00000001, 1'b1, 0);
        convert(32'hFFFFFFFF, 1'b1, 0);
        convert(32'hFFFFFFFF, 1'b0, 0);
        convert(32'h80000000, 1'b1, 0);
        convert(32'h7FFFFFFF, 1'b0, 0);
        convert(32'h01000001, 1'b0, 0);
        convert(32'h00000000, 1'b1, 0);
        convert(32'h00000000, 1'b0, 0);
        convert(32'h80000000, 1'b0, 0);
        convert(32'h01000003, 1'b1, 0);

        for (int k = 0; k < 40; k++) begin
            rv = $urandom >> $urandom_range(0, 31);
            convert(rv, 1'($urandom_range(0, 1)), 0);
        end

        convert(32'hFFFFFFFF, 1'b0, 10);

        // Abort an operation in NORM with a reset.
        int_in = 32'h00000001; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_norm_busy", {30'd0, in_ready0, out_valid0}, 32'd0);
        chk("rst_norm_float", float0, 32'd0);
        chk("rst_norm_flags", {30'd0, pl0, zero0}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release", {30'd0, in_ready0, out_valid0}, 32'd2);
        chk("rst_release_float", float0, 32'd0);

        convert(32'h00001234, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
